// File: rtl/mem_loader_if.sv
// Byte-stream loader bus: control/status, byte stream handshake and memory write port.
interface mem_loader_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 256
);
  localparam int unsigned CW = $clog2(LENGTH) + 1;

  logic             start;
  logic [WIDTH-1:0] base_addr;
  logic [CW-1:0]    word_count;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       checksum;

  modport master (
    output start, base_addr, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wd, busy, done, err, checksum
  );

  modport slave (
    input  start, base_addr, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wd, busy, done, err, checksum
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream little-endian into 32-bit words and writes
// them to consecutive word addresses (wrapping at LENGTH words).
// Optional running byte checksum enabled by defining LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  mem_loader_if.slave bus
);
  localparam int unsigned CW = $clog2(LENGTH) + 1;
  localparam int unsigned IW = WIDTH - 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      buf_q, buf_d;
  logic             byte_ready_q, byte_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic accept;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    mem_we_d    = 1'b0;
    err_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    accept = byte_ready_q && bus.byte_valid;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.base_addr[1:0] != 2'b00) || (bus.base_addr[WIDTH-1:2] > LAST_IDX)) begin
            err_d = 1'b1;
          end else begin
            addr_d      = bus.base_addr;
            remaining_d = bus.word_count;
            byte_idx_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d      = 8'd0;
`endif
            state_d     = (bus.word_count == '0) ? FINISH : COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q + bus.byte_in;
`endif
          case (byte_idx_q)
            2'd0: buf_d[7:0]   = bus.byte_in;
            2'd1: buf_d[15:8]  = bus.byte_in;
            2'd2: buf_d[23:16] = bus.byte_in;
            default: begin
              mem_wd_d   = WIDTH'({bus.byte_in, buf_q});
              mem_addr_d = addr_q;
              mem_we_d   = 1'b1;
              state_d    = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        remaining_d = remaining_q - CW'(1);
        if (remaining_q == CW'(1)) begin
          state_d = FINISH;
        end else begin
          state_d = COLLECT;
          addr_d  = (addr_q[WIDTH-1:2] == LAST_IDX) ? '0 : addr_q + WIDTH'(4);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    byte_ready_d = (state_d == COLLECT);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FINISH);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      byte_idx_q   <= 2'd0;
      buf_q        <= 24'd0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wd     = mem_wd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum   = csum_q;
`else
  assign bus.checksum   = 8'd0;
`endif

endmodule
